// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// state enum, opcode/funct constants, datapath select encodings and the per-state decode.
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        S_START, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EX, S_R_WB, S_ANDI_EX, S_ANDI_WB, S_BRANCH, S_JUMP, S_JR,
        S_MUL, S_MF_WB, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_LO   = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       hilo_write;
        logic [1:0] hilo_sel;
        logic       illegal;
        logic       busy;
    } ctrl_t;

    // FETCH's ir_write/pc_write are further qualified by mem_ready in the top.
    function automatic ctrl_t state_ctrl(state_t s, logic mf_lo, logic mul_last);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_START) && (s != S_FETCH);
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_ADD;
                              c.ir_write = 1'b1; c.pc_write = 1'b1; end
            S_DECODE:   begin c.alu_src_b = SRCB_IMM2; c.alu_op = ALU_ADD; end
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_R_EX:     begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_FUNCT; end
            S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_ANDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_AND; end
            S_ANDI_WB:  c.reg_write = 1'b1;
            S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1;
                              c.pc_source = PCSRC_ALUOUT; end
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
            S_JR:       begin c.pc_write = 1'b1; c.pc_source = PCSRC_REGA; end
            S_MUL:      c.hilo_write = mul_last;
            S_MF_WB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1;
                              c.hilo_sel = mf_lo ? HILO_LO : HILO_HI; end
            S_TRAP:     c.illegal = 1'b1;
            default:    c.hilo_sel = HILO_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mul_cycle_counter.sv
// Down-counter that paces the MULTU execute phase; done marks the final cycle,
// last marks the cycle before it so the product strobe can be registered.
module mul_cycle_counter #(
    parameter int                CNT_W    = 5,
    parameter logic [CNT_W-1:0]  LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done,
    output logic last
);

    logic [CNT_W-1:0] count_r;

    // Load on MUL entry, then count down to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);
    assign last = (count_r == CNT_W'(1));

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: registered FSM with registered control outputs,
// memory-ready handshake, multi-cycle MULTU, JR and illegal-instruction trap.
module mc_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W       = 6,
    parameter int FUNCT_W    = 6,
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = $clog2(MUL_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               hilo_write,
    output logic [1:0]         hilo_sel,
    output logic               illegal,
    output logic               busy
);

    state_t state_r, next_state_s, dispatch_s;
    ctrl_t  ctrl_r;
    logic   mul_load_s, mul_dec_s, mul_done_s, mul_last_s, mf_lo_s;
    logic   unused_zero_s;

    // zero qualifies pc_write_cond in the datapath, not here.
    assign unused_zero_s = zero;
    assign mf_lo_s       = (funct == FUNCT_W'(FN_MFLO));

    // Instruction dispatch out of DECODE.
    always_comb begin
        dispatch_s = S_TRAP;
        case (opcode)
            OP_W'(OP_LW), OP_W'(OP_SW): dispatch_s = S_MEM_ADDR;
            OP_W'(OP_BEQ):              dispatch_s = S_BRANCH;
            OP_W'(OP_J):                dispatch_s = S_JUMP;
            OP_W'(OP_ANDI):             dispatch_s = S_ANDI_EX;
            OP_W'(OP_RTYPE): begin
                case (funct)
                    FUNCT_W'(FN_JR):                      dispatch_s = S_JR;
                    FUNCT_W'(FN_MULTU):                   dispatch_s = S_MUL;
                    FUNCT_W'(FN_MFHI), FUNCT_W'(FN_MFLO): dispatch_s = S_MF_WB;
                    FUNCT_W'(FN_ADD), FUNCT_W'(FN_SUB), FUNCT_W'(FN_AND),
                    FUNCT_W'(FN_OR), FUNCT_W'(FN_SLT), FUNCT_W'(FN_SLL):
                                                          dispatch_s = S_R_EX;
                    default:                              dispatch_s = S_TRAP;
                endcase
            end
            default: dispatch_s = S_TRAP;
        endcase
    end

    // Next-state sequencing; only FETCH, MEM_RD and MEM_WR wait on mem_ready.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_START:    next_state_s = S_FETCH;
            S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   next_state_s = dispatch_s;
            S_MEM_ADDR: next_state_s = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state_s = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:     next_state_s = S_R_WB;
            S_ANDI_EX:  next_state_s = S_ANDI_WB;
            S_MUL:      next_state_s = mul_done_s ? S_FETCH : S_MUL;
            default:    next_state_s = S_FETCH;
        endcase
    end

    assign mul_load_s = (state_r == S_DECODE) && (dispatch_s == S_MUL);
    assign mul_dec_s  = (state_r == S_MUL);

    mul_cycle_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (CNT_W'(MUL_CYCLES - 1))
    ) u_mul_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load_s),
        .dec  (mul_dec_s),
        .done (mul_done_s),
        .last (mul_last_s)
    );

    // State and controls are registered together so controls track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_START;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= state_ctrl(next_state_s, mf_lo_s, mul_last_s && (state_r == S_MUL));
        end
    end

    // The fetch strobes commit only in the cycle memory delivers the instruction.
    assign pc_write      = ctrl_r.pc_write && ((state_r != S_FETCH) || mem_ready);
    assign ir_write      = ctrl_r.ir_write && mem_ready;
    assign pc_write_cond = ctrl_r.pc_write_cond;
    assign iord          = ctrl_r.iord;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign mem_to_reg    = ctrl_r.mem_to_reg;
    assign reg_dst       = ctrl_r.reg_dst;
    assign reg_write     = ctrl_r.reg_write;
    assign alu_src_a     = ctrl_r.alu_src_a;
    assign alu_src_b     = ctrl_r.alu_src_b;
    assign alu_op        = ctrl_r.alu_op;
    assign pc_source     = ctrl_r.pc_source;
    assign hilo_write    = ctrl_r.hilo_write;
    assign hilo_sel      = ctrl_r.hilo_sel;
    assign illegal       = ctrl_r.illegal;
    assign busy          = ctrl_r.busy;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: each instruction is expanded into its expected cycle
// sequence and every cycle's control vector is compared at the falling edge.
`timescale 1ns/100ps
module tb_mc_control_unit;

    localparam int MULN = 4;

    logic clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00, funct = 6'h00;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, hilo_write, illegal, busy;
    logic [1:0] alu_src_b, alu_op, pc_source, hilo_sel;

    typedef struct packed {
        logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic hilo_write;
        logic [1:0] hilo_sel;
        logic illegal, busy;
    } vec_t;

    typedef enum {K_FETCH, K_DECODE, K_ADDR, K_RD, K_MWB, K_WR, K_REX, K_RWB, K_AEX, K_AWB,
                  K_BR, K_J, K_JR, K_MUL, K_MULEND, K_MFHI, K_MFLO, K_TRAP} kind_t;

    vec_t obs;
    int   checks = 0, failures = 0;

    mc_control_unit #(.OP_W(6), .FUNCT_W(6), .MUL_CYCLES(MULN)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .hilo_write(hilo_write), .hilo_sel(hilo_sel),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, hilo_write,
                  hilo_sel, illegal, busy};

    // Control vector the datasheet table gives for one cycle of a given kind.
    function automatic vec_t expect_of(kind_t k, logic rdy);
        vec_t v;
        v      = '0;
        v.busy = (k != K_FETCH);
        case (k)
            K_FETCH:  begin v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
            K_DECODE: v.alu_src_b = 2'b11;
            K_ADDR:   begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
            K_RD:     begin v.mem_read = 1'b1; v.iord = 1'b1; end
            K_MWB:    begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; end
            K_WR:     begin v.mem_write = 1'b1; v.iord = 1'b1; end
            K_REX:    begin v.alu_src_a = 1'b1; v.alu_op = 2'b10; end
            K_RWB:    begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
            K_AEX:    begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 2'b11; end
            K_AWB:    v.reg_write = 1'b1;
            K_BR:     begin v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_write_cond = 1'b1; v.pc_source = 2'b01; end
            K_J:      begin v.pc_write = 1'b1; v.pc_source = 2'b10; end
            K_JR:     begin v.pc_write = 1'b1; v.pc_source = 2'b11; end
            K_MULEND: v.hilo_write = 1'b1;
            K_MFHI:   begin v.reg_write = 1'b1; v.reg_dst = 1'b1; v.hilo_sel = 2'b10; end
            K_MFLO:   begin v.reg_write = 1'b1; v.reg_dst = 1'b1; v.hilo_sel = 2'b11; end
            K_TRAP:   v.illegal = 1'b1;
            default:  ;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input kind_t k, input logic rdy);
        @(posedge clk);
        #1 mem_ready = rdy;
        @(negedge clk);
        check(k.name(), expect_of(k, rdy));
    endtask

    // One instruction: sf fetch stalls, sm stalls in the memory access cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int sf, input int sm);
        kind_t plan[$];
        opcode = op;
        funct  = fn;
        repeat (sf) step(K_FETCH, 1'b0);
        step(K_FETCH, 1'b1);
        plan.push_back(K_DECODE);
        case (op)
            6'h23: begin plan.push_back(K_ADDR); plan.push_back(K_RD); plan.push_back(K_MWB); end
            6'h2B: begin plan.push_back(K_ADDR); plan.push_back(K_WR); end
            6'h04: plan.push_back(K_BR);
            6'h02: plan.push_back(K_J);
            6'h0C: begin plan.push_back(K_AEX); plan.push_back(K_AWB); end
            6'h00: begin
                case (fn)
                    6'h08: plan.push_back(K_JR);
                    6'h19: begin repeat (MULN - 1) plan.push_back(K_MUL); plan.push_back(K_MULEND); end
                    6'h10: plan.push_back(K_MFHI);
                    6'h12: plan.push_back(K_MFLO);
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00: begin plan.push_back(K_REX); plan.push_back(K_RWB); end
                    default: plan.push_back(K_TRAP);
                endcase
            end
            default: plan.push_back(K_TRAP);
        endcase
        foreach (plan[i]) begin
            if (plan[i] == K_RD || plan[i] == K_WR) begin
                repeat (sm) step(plan[i], 1'b0);
                step(plan[i], 1'b1);
            end else begin
                step(plan[i], 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int sel;
        mem_ready = 1'b1;
        #2 rst = 1'b1;
        #1 check("reset_async", '0);
        repeat (2) @(negedge clk);
        check("reset_held", '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("start", '0);

        run_instr(6'h23, 6'h00, 0, 2);   // LW, two memory stalls
        run_instr(6'h00, 6'h20, 0, 0);   // ADD
        run_instr(6'h00, 6'h19, 0, 0);   // MULTU
        run_instr(6'h04, 6'h00, 0, 0);   // BEQ
        run_instr(6'h00, 6'h08, 0, 0);   // JR
        run_instr(6'h3F, 6'h00, 0, 0);   // illegal opcode
        run_instr(6'h2B, 6'h00, 1, 1);   // SW with stalls
        run_instr(6'h0C, 6'h00, 2, 0);   // ANDI with fetch stalls
        run_instr(6'h00, 6'h12, 0, 0);   // MFLO

        // Reset pulse in the middle of a multiply.
        opcode = 6'h00; funct = 6'h19;
        step(K_FETCH, 1'b1);
        step(K_DECODE, 1'b1);
        step(K_MUL, 1'b0);
        step(K_MUL, 1'b1);
        #1 rst = 1'b1;
        #1 check("rst_mid_mul", '0);
        #2 rst = 1'b0;
        #0.5 check("start_after_rst", '0);
        run_instr(6'h00, 6'h19, 0, 0);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 15));
            fn  = 6'h00;
            case (sel)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: op = 6'h04;
                3: op = 6'h02;
                4: op = 6'h0C;
                5: begin op = 6'h00; fn = 6'h08; end
                6: begin op = 6'h00; fn = 6'h19; end
                7: begin op = 6'h00; fn = 6'h10; end
                8: begin op = 6'h00; fn = 6'h12; end
                9: begin op = 6'h00; fn = 6'h20; end
                10: begin op = 6'h00; fn = 6'h22; end
                11: begin op = 6'h00; fn = 6'h2A; end
                12: begin op = 6'h00; fn = 6'h00; end
                13: begin
                    op = 6'h00;
                    fn = 6'($urandom_range(0, 63));
                    while (fn inside {6'h00, 6'h08, 6'h10, 6'h12, 6'h19, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
                        fn = 6'($urandom_range(0, 63));
                end
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op inside {6'h00, 6'h02, 6'h04, 6'h0C, 6'h23, 6'h2B})
                        op = 6'($urandom_range(0, 63));
                    fn = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
